// File: rtl/sign_magnitude_decoder_if.sv
// rtl/sign_magnitude_decoder_if.sv - start/busy/done handshake and operand/result bus
// Master requests conversions; slave is the decoder.
interface sign_magnitude_decoder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] IN;
  logic             busy;
  logic             done;
  logic             SIGN;
  logic [WIDTH-1:0] MAG;

  modport master (
    output start,
    output IN,
    input  busy,
    input  done,
    input  SIGN,
    input  MAG
  );

  modport slave (
    input  start,
    input  IN,
    output busy,
    output done,
    output SIGN,
    output MAG
  );
endinterface

// File: rtl/sign_magnitude_decoder.sv
// rtl/sign_magnitude_decoder.sv - bit-serial two's-complement to sign-magnitude converter
// Copies bits LSB-first up to and including the first 1, then inverts the rest when negative.
module sign_magnitude_decoder #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  sign_magnitude_decoder_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mag_q;
  logic [CW-1:0]    cnt_q;
  logic             seen_q;
  logic             seen_d;
  logic             neg_q;
  logic             sign_q;
  logic             busy_q;
  logic             done_q;
  logic             out_bit;
  logic             last_bit;

  always_comb begin
    out_bit  = sr_q[0] ^ (neg_q & seen_q);
    seen_d   = seen_q | sr_q[0];
    acc_d    = {out_bit, acc_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      neg_q   <= 1'b0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sr_q    <= bus.IN;
            neg_q   <= bus.IN[WIDTH-1];
            cnt_q   <= '0;
            acc_q   <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          sr_q   <= sr_q >> 1;
          seen_q <= seen_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q + 1'b1;
          // Results publish only on the final bit so they stay stable during the next run.
          if (last_bit) begin
            mag_q   <= acc_d;
            sign_q  <= neg_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.SIGN = sign_q;
  assign bus.MAG  = mag_q;

endmodule
